jtopll_wrq: RTL

- Parametrised register-write front end for the OPLL-family FM core.
- Captures CPU address/data writes at clk speed into a DEPTH-entry queue and emulates chip write-wait timing through a busy flag.
- Drains one write per operator cen, decoded into channel/group/subslot select and update strobes for the register file.
- Generalises the fixed 9-channel decoder: configurable channel count, queue depth and wait times, plus overflow reporting.

---
 rtl/jtopll_wrq.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/jtopll_wrq.sv
// jtopll_wrq: CPU register-write queue and decoder for the OPLL-family FM core.
// Latency: a data write at edge N with cenop at N+1 gives an update pulse after edge N+2.
// Backpressure: busy is advisory only; a data write to a full queue (no pop) is dropped and sets overflow.
module jtopll_wrq #(
  parameter int CHANNELS  = 9,
  parameter int DEPTH     = 4,
  parameter int ADDR_WAIT = 12,
  parameter int DATA_WAIT = 84
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cenop,
  input  logic       write,
  input  logic       addr,
  input  logic [7:0] din,
  output logic       busy,
  output logic       overflow,
  output logic       upd_valid,
  output logic [7:0] upd_din,
  output logic [3:0] sel_ch,
  output logic [1:0] sel_group,
  output logic [2:0] sel_sub,
  output logic       up_original,
  output logic       up_fnumlo,
  output logic       up_fnumhi,
  output logic       up_inst,
  output logic       up_rhy,
  output logic       am_dep,
  output logic       vib_dep,
  output logic       rhy_en,
  output logic [4:0] rhy_kon
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = AW + 1;
  localparam int WMAX = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
  localparam int TW   = (WMAX < 2) ? 1 : $clog2(WMAX + 1);
  localparam logic [4:0]    CH_LIMIT = 5'(CHANNELS);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Register selected by the last address write; tags every queued data byte
  logic [7:0]    selreg;

  // Queue storage: {register, data} per entry
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          full;
  logic          full_nxt;
  logic          empty;

  logic          addr_wr;
  logic          data_wr;
  logic          push;
  logic          pop;

  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nxt;

  // Entry popped this cycle, decoded on the following edge
  logic          stage_valid;
  logic [7:0]    stage_reg;
  logic [7:0]    stage_din;
  logic          is_chan;
  logic [4:0]    chan_info;

  assign addr_wr = write & ~addr;
  assign data_wr = write & addr;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign pop     = cenop & ~empty;
  // A full queue still accepts a write when a slot frees in the same clk
  assign push    = data_wr & (~full | pop);

  // Channel registers: 0x1n/0x2n/0x3n with n inside the configured channel range
  assign is_chan = (stage_reg[7:4] >= 4'h1) && (stage_reg[7:4] <= 4'h3) &&
                   ({1'b0, stage_reg[3:0]} < CH_LIMIT);

  // Channel to {group, subslot}; groups beyond 3 saturate
  function automatic logic [4:0] chan_map(input logic [3:0] ch);
    case (ch)
      4'd0:    chan_map = {2'd0, 3'd0};
      4'd1:    chan_map = {2'd0, 3'd1};
      4'd2:    chan_map = {2'd0, 3'd2};
      4'd3:    chan_map = {2'd1, 3'd0};
      4'd4:    chan_map = {2'd1, 3'd1};
      4'd5:    chan_map = {2'd1, 3'd2};
      4'd6:    chan_map = {2'd2, 3'd0};
      4'd7:    chan_map = {2'd2, 3'd1};
      4'd8:    chan_map = {2'd2, 3'd2};
      4'd9:    chan_map = {2'd3, 3'd0};
      4'd10:   chan_map = {2'd3, 3'd1};
      4'd11:   chan_map = {2'd3, 3'd2};
      4'd12:   chan_map = {2'd3, 3'd0};
      4'd13:   chan_map = {2'd3, 3'd1};
      4'd14:   chan_map = {2'd3, 3'd2};
      default: chan_map = {2'd3, 3'd0};
    endcase
  endfunction

  assign chan_info = chan_map(stage_reg[3:0]);

  // Next occupancy from the push/pop pair
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  assign full_nxt = (count_nxt == FULL_CNT);

  // Write-wait timer: a new write restarts it, otherwise count down to zero
  always_comb begin
    timer_nxt = timer;
    if (addr_wr) begin
      timer_nxt = TW'(ADDR_WAIT);
    end else if (data_wr) begin
      timer_nxt = TW'(DATA_WAIT);
    end else if (timer != '0) begin
      timer_nxt = timer - TW'(1);
    end
  end

  // Queue pointers, selected register, wait timer and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      selreg   <= 8'h00;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      timer    <= '0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (addr_wr) selreg <= din;
      if (push)    wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      timer <= timer_nxt;
      busy  <= (timer_nxt != '0) | full_nxt;
      if (data_wr && !push) overflow <= 1'b1;
    end
  end

  // Queue storage needs no reset; occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {selreg, din};
  end

  // Capture the head entry on a drain slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid <= 1'b0;
      stage_reg   <= 8'h00;
      stage_din   <= 8'h00;
    end else begin
      stage_valid <= pop;
      if (pop) {stage_reg, stage_din} <= mem[rd_ptr];
    end
  end

  // Decode the staged entry: one-cycle strobes, held selects and rhythm state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_valid   <= 1'b0;
      upd_din     <= 8'h00;
      sel_ch      <= 4'h0;
      sel_group   <= 2'd0;
      sel_sub     <= 3'd0;
      up_original <= 1'b0;
      up_fnumlo   <= 1'b0;
      up_fnumhi   <= 1'b0;
      up_inst     <= 1'b0;
      up_rhy      <= 1'b0;
      am_dep      <= 1'b0;
      vib_dep     <= 1'b0;
      rhy_en      <= 1'b0;
      rhy_kon     <= 5'd0;
    end else begin
      upd_valid   <= stage_valid;
      up_original <= 1'b0;
      up_fnumlo   <= 1'b0;
      up_fnumhi   <= 1'b0;
      up_inst     <= 1'b0;
      up_rhy      <= 1'b0;
      if (stage_valid) begin
        upd_din <= stage_din;
        if (stage_reg < 8'h08) begin
          up_original <= 1'b1;
          sel_sub     <= stage_reg[2:0];
        end else if (is_chan) begin
          up_fnumlo <= (stage_reg[7:4] == 4'h1);
          up_fnumhi <= (stage_reg[7:4] == 4'h2);
          up_inst   <= (stage_reg[7:4] == 4'h3);
          sel_ch    <= stage_reg[3:0];
          sel_group <= chan_info[4:3];
          sel_sub   <= chan_info[2:0];
        end else if (stage_reg == 8'h0E) begin
          up_rhy  <= 1'b1;
          am_dep  <= stage_din[7];
          vib_dep <= stage_din[6];
          rhy_en  <= stage_din[5];
          rhy_kon <= stage_din[4:0];
        end
      end
    end
  end

endmodule
